// File: rtl/wb_master_pkg.sv
// Shared types and constants for the Wishbone burst master: FSM states,
// cycle-type identifiers and the beat-counter width.
package wb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_WSTALL,
        ST_DONE
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int BEAT_W = 8;

    // A zero-length request still moves one beat.
    function automatic logic [BEAT_W-1:0] norm_len(input logic [BEAT_W-1:0] len);
        return (len == '0) ? BEAT_W'(1) : len;
    endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// Ack-timeout counter: counts enabled cycles and flags the cycle whose
// increment would reach 2**TMO_W-1, so the caller can abort on that edge.
module wb_ack_timer #(
    parameter int TMO_W = 10
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [TMO_W-1:0] LIMIT_M1 = TMO_W'((2 ** TMO_W) - 2);

    logic [TMO_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + TMO_W'(1);
        end
    end

    assign o_expired = i_enable && (r_count == LIMIT_M1);

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone incrementing-burst master: turns one command into cmd_len beats,
// streams write data in / read data out, and aborts on an ack timeout.
module wb_burst_master
    import wb_master_pkg::*;
#(
    parameter int dw     = 32,
    parameter int APP_AW = 26,
    parameter int TMO_W  = 10
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [APP_AW-1:0]   cmd_addr,
    input  logic                cmd_we,
    input  logic [BEAT_W-1:0]   cmd_len,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [dw-1:0]       wr_data,
    input  logic [dw/8-1:0]     wr_sel,
    output logic                rd_valid,
    output logic [dw-1:0]       rd_data,
    output logic                rd_last,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [APP_AW-1:0]   wb_addr_o,
    output logic [dw-1:0]       wb_dat_o,
    output logic [dw/8-1:0]     wb_sel_o,
    output logic [2:0]          wb_cti_o,
    input  logic                wb_ack_i,
    input  logic [dw-1:0]       wb_dat_i,
    output logic                busy,
    output logic                err
);

    localparam logic [APP_AW-1:0] ADDR_STEP = APP_AW'(dw / 8);

    state_t              r_state;
    state_t              w_next;
    logic [APP_AW-1:0]   r_addr;
    logic                r_we;
    logic [BEAT_W-1:0]   r_len;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_err;

    logic w_in_xfer, w_stall, w_stb, w_beat_done, w_last;
    logic w_accept, w_expired, w_timeout;

    assign w_in_xfer   = (r_state == ST_XFER);
    assign w_last      = (r_beat == r_len - BEAT_W'(1));
    // Strobe is withheld while write data is missing so no beat is acked with stale data.
    assign w_stall     = w_in_xfer && r_we && !wr_valid;
    assign w_stb       = w_in_xfer && !w_stall;
    assign w_beat_done = w_stb && wb_ack_i;
    assign w_accept    = (r_state == ST_IDLE) && cmd_valid;

    wb_ack_timer #(.TMO_W(TMO_W)) u_ack_timer (
        .i_clk     (sys_clk),
        .i_reset   (reset),
        .i_clear   (w_accept || w_beat_done),
        .i_enable  (w_in_xfer && !wb_ack_i),
        .o_expired (w_expired)
    );

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        wb_cyc_o  = 1'b0;
        wb_cti_o  = CTI_CLASSIC;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = !reset;
                if (cmd_valid) w_next = ST_XFER;
            end
            ST_XFER: begin
                busy     = 1'b1;
                wb_cyc_o = 1'b1;
                wb_cti_o = w_last ? CTI_EOB : CTI_INCR;
                if (w_beat_done) begin
                    if (w_last) w_next = ST_DONE;
                end else if (w_expired) begin
                    w_next    = ST_DONE;
                    w_timeout = 1'b1;
                end else if (w_stall) begin
                    w_next = ST_WSTALL;
                end
            end
            ST_WSTALL: begin
                busy     = 1'b1;
                wb_cyc_o = 1'b1;
                if (wr_valid) w_next = ST_XFER;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_addr <= '0;
            r_we   <= 1'b0;
            r_len  <= '0;
            r_beat <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (w_accept) begin
                r_addr <= cmd_addr;
                r_we   <= cmd_we;
                r_len  <= norm_len(cmd_len);
                r_beat <= '0;
            end else if (w_beat_done) begin
                r_addr <= r_addr + ADDR_STEP;
                r_beat <= r_beat + BEAT_W'(1);
            end
        end
    end

    assign wb_stb_o  = w_stb;
    assign wb_we_o   = busy && r_we;
    assign wb_addr_o = r_addr;
    assign wb_dat_o  = wb_we_o ? wr_data : '0;
    assign wb_sel_o  = wb_we_o ? wr_sel : '0;
    assign wr_ready  = w_beat_done && r_we;
    assign rd_valid  = w_beat_done && !r_we;
    assign rd_data   = rd_valid ? wb_dat_i : '0;
    assign rd_last   = rd_valid && w_last;
    assign err       = r_err;

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: a reactive slave drives acks, and
// scoreboard queues hold the expected bus beats and read-data deliveries.
module tb_wb_burst_master;

    localparam int DW    = 32;
    localparam int AW    = 26;
    localparam int TMO_W = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [2:0]    cti;
        logic          we;
        logic [DW-1:0] dat;
        logic [3:0]    sel;
    } beat_t;

    typedef struct {
        logic [DW-1:0] dat;
        logic          last;
    } rd_t;

    logic          sys_clk = 1'b0;
    logic          reset   = 1'b1;
    logic          cmd_valid = 1'b0, cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [7:0]    cmd_len = '0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [3:0]    wr_sel = '0;
    logic          wb_ack_i = 1'b0;
    logic [DW-1:0] wb_dat_i = '0;
    logic          cmd_ready, wr_ready, rd_valid, rd_last;
    logic [DW-1:0] rd_data, wb_dat_o;
    logic          wb_cyc_o, wb_stb_o, wb_we_o, busy, err;
    logic [AW-1:0] wb_addr_o;
    logic [3:0]    wb_sel_o;
    logic [2:0]    wb_cti_o;

    wb_burst_master #(.dw(DW), .APP_AW(AW), .TMO_W(TMO_W)) dut (
        .sys_clk(sys_clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_we(cmd_we), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_sel(wr_sel),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i),
        .busy(busy), .err(err)
    );

    initial forever #5 sys_clk = ~sys_clk;

    int checks = 0, errors = 0;
    int wrr_cnt = 0, rdv_cnt = 0, rdl_cnt = 0, err_cnt = 0;
    beat_t beat_q[$];
    rd_t   rd_q[$];
    beat_t mon_b;
    rd_t   mon_r;
    logic [DW-1:0] wd[256];
    logic [3:0]    ws[256];
    bit cur_we;
    int cur_len;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: every accepted beat and every read delivery is matched against the scoreboard.
    always @(negedge sys_clk) begin
        if (!reset) begin
            if (wr_ready) wrr_cnt++;
            if (rd_valid) rdv_cnt++;
            if (rd_last)  rdl_cnt++;
            if (err)      err_cnt++;
            if (wb_stb_o && wb_ack_i) begin
                checks++;
                assert (beat_q.size() > 0) else begin
                    errors++;
                    $error("FAIL beat_unexpected: observed beat at 0x%0h, required none", wb_addr_o);
                end
                if (beat_q.size() > 0) begin
                    mon_b = beat_q.pop_front();
                    check("beat_addr", 64'(wb_addr_o), 64'(mon_b.addr));
                    check("beat_cti", 64'(wb_cti_o), 64'(mon_b.cti));
                    check("beat_we", 64'(wb_we_o), 64'(mon_b.we));
                    if (mon_b.we) begin
                        check("beat_wdat", 64'(wb_dat_o), 64'(mon_b.dat));
                        check("beat_wsel", 64'(wb_sel_o), 64'(mon_b.sel));
                        check("beat_wr_ready", 64'(wr_ready), 64'(1));
                    end
                end
            end
            if (rd_valid) begin
                checks++;
                assert (rd_q.size() > 0) else begin
                    errors++;
                    $error("FAIL rd_unexpected: observed rd_valid with 0x%0h, required none", rd_data);
                end
                if (rd_q.size() > 0) begin
                    mon_r = rd_q.pop_front();
                    check("rd_data", 64'(rd_data), 64'(mon_r.dat));
                    check("rd_last", 64'(rd_last), 64'(mon_r.last));
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_cyc"}, 64'(wb_cyc_o), 0);
        check({tag, "_stb"}, 64'(wb_stb_o), 0);
        check({tag, "_we"}, 64'(wb_we_o), 0);
        check({tag, "_cti"}, 64'(wb_cti_o), 0);
        check({tag, "_addr"}, 64'(wb_addr_o), 0);
        check({tag, "_sel"}, 64'(wb_sel_o), 0);
        check({tag, "_dat"}, 64'(wb_dat_o), 0);
        check({tag, "_rd_valid"}, 64'(rd_valid), 0);
        check({tag, "_rd_last"}, 64'(rd_last), 0);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_err"}, 64'(err), 0);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 0);
    endtask

    task automatic issue(input logic [AW-1:0] a, input bit we, input logic [7:0] len);
        beat_t b;
        int n;
        n = (len == 8'd0) ? 1 : int'(len);
        cur_we  = we;
        cur_len = n;
        for (int k = 0; k < n; k++) begin
            wd[k]  = $urandom;
            ws[k]  = 4'($urandom_range(1, 15));
            b.addr = a + AW'(4 * k);
            b.cti  = (k == n - 1) ? 3'b111 : 3'b010;
            b.we   = we;
            b.dat  = wd[k];
            b.sel  = ws[k];
            beat_q.push_back(b);
        end
        cmd_addr  = a;
        cmd_we    = we;
        cmd_len   = len;
        cmd_valid = 1'b1;
        @(negedge sys_clk);
        check("cmd_ready_idle", 64'(cmd_ready), 1);
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
        check("busy_after_accept", 64'(busy), 1);
    endtask

    // Slave model: acks after `gap` strobed cycles (gap<0: never), optionally
    // withholds write data or asserts reset at a given beat index.
    task automatic serve(input int gap, input int stall_at, input int stall_len,
                         input int abort_at, input int budget, output int ncyc);
        int  idx = 0, waited = 0, stalled = 0;
        bit  acked, stall_now, aborted = 1'b0;
        rd_t r;
        ncyc = 0;
        while (busy === 1'b1 && ncyc < budget) begin
            ncyc++;
            wr_data   = wd[idx];
            wr_sel    = ws[idx];
            stall_now = (idx == stall_at) && (stalled < stall_len);
            if (stall_now) stalled++;
            wr_valid = !stall_now;
            if (idx == abort_at) begin
                reset   = 1'b1;
                aborted = 1'b1;
            end
            #1;
            acked = 1'b0;
            if (!aborted && wb_stb_o && gap >= 0 && waited >= gap) begin
                wb_ack_i = 1'b1;
                wb_dat_i = $urandom;
                acked    = 1'b1;
                if (!cur_we) begin
                    r.dat  = wb_dat_i;
                    r.last = (idx == cur_len - 1);
                    rd_q.push_back(r);
                end
            end else begin
                wb_ack_i = 1'b0;
                if (wb_stb_o) waited++;
            end
            @(negedge sys_clk);
            if (stall_now) begin
                check("stall_stb_low", 64'(wb_stb_o), 0);
                check("stall_cyc_high", 64'(wb_cyc_o), 1);
                check("stall_no_err", 64'(err), 0);
            end
            @(posedge sys_clk); #1;
            wb_ack_i = 1'b0;
            if (acked) begin
                idx++;
                waited = 0;
            end
            if (aborted) break;
        end
        wr_valid = 1'b0;
        if (!aborted) check("burst_ended", 64'(busy), 0);
    endtask

    task automatic finish_burst(input bit exp_err);
        check("done_cyc", 64'(wb_cyc_o), 0);
        check("done_stb", 64'(wb_stb_o), 0);
        check("done_err", 64'(err), 64'(exp_err));
        check("done_cmd_ready", 64'(cmd_ready), 0);
        @(posedge sys_clk); #1;
        check("idle_cmd_ready", 64'(cmd_ready), 1);
        check("idle_err", 64'(err), 0);
    endtask

    initial begin
        int n, wrr0, rdv0, rdl0, err0;

        repeat (2) @(posedge sys_clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        #1;
        check("release_cmd_ready", 64'(cmd_ready), 1);

        // Write burst, back-to-back acks.
        wrr0 = wrr_cnt; err0 = err_cnt;
        issue(26'h100, 1'b1, 8'd4);
        serve(0, -1, 0, -1, 50, n);
        check("wr4_cycles", 64'(n), 4);
        finish_burst(1'b0);
        check("wr4_wr_ready_pulses", 64'(wrr_cnt - wrr0), 4);
        check("wr4_beats_left", 64'(beat_q.size()), 0);

        // Read burst, acks after two idle strobe cycles.
        wrr0 = wrr_cnt; rdv0 = rdv_cnt; rdl0 = rdl_cnt;
        issue(26'h2000, 1'b0, 8'd8);
        serve(2, -1, 0, -1, 100, n);
        finish_burst(1'b0);
        check("rd8_rd_valid_pulses", 64'(rdv_cnt - rdv0), 8);
        check("rd8_rd_last_pulses", 64'(rdl_cnt - rdl0), 1);
        check("rd8_no_wr_ready", 64'(wrr_cnt - wrr0), 0);
        check("rd8_rd_left", 64'(rd_q.size()), 0);
        check("rd8_beats_left", 64'(beat_q.size()), 0);

        // Write data withheld for five cycles before the second beat.
        wrr0 = wrr_cnt; err0 = err_cnt;
        issue(26'h400, 1'b1, 8'd3);
        serve(0, 1, 5, -1, 60, n);
        finish_burst(1'b0);
        check("stall_wr_ready_pulses", 64'(wrr_cnt - wrr0), 3);
        check("stall_err_pulses", 64'(err_cnt - err0), 0);
        check("stall_beats_left", 64'(beat_q.size()), 0);

        // Silent slave: abort after 15 cycles in XFER.
        rdv0 = rdv_cnt; rdl0 = rdl_cnt; err0 = err_cnt;
        issue(26'h800, 1'b0, 8'd2);
        serve(-1, -1, 0, -1, 100, n);
        check("tmo_xfer_cycles", 64'(n), 15);
        finish_burst(1'b1);
        check("tmo_err_pulses", 64'(err_cnt - err0), 1);
        check("tmo_no_rd_valid", 64'(rdv_cnt - rdv0), 0);
        check("tmo_no_rd_last", 64'(rdl_cnt - rdl0), 0);
        check("tmo_beats_unissued", 64'(beat_q.size()), 2);
        beat_q.delete();

        // Zero length means one beat, tagged end-of-burst.
        rdv0 = rdv_cnt; rdl0 = rdl_cnt;
        issue(26'h40, 1'b0, 8'd0);
        serve(1, -1, 0, -1, 20, n);
        finish_burst(1'b0);
        check("len0_rd_valid_pulses", 64'(rdv_cnt - rdv0), 1);
        check("len0_rd_last_pulses", 64'(rdl_cnt - rdl0), 1);
        check("len0_beats_left", 64'(beat_q.size()), 0);

        // Address wraps at the top of the byte-address space.
        issue(26'h3FFFFFC, 1'b1, 8'd2);
        serve(0, -1, 0, -1, 20, n);
        finish_burst(1'b0);
        check("wrap_beats_left", 64'(beat_q.size()), 0);

        // Reset during the third beat of an eight-beat read.
        rdv0 = rdv_cnt; err0 = err_cnt;
        issue(26'h3000, 1'b0, 8'd8);
        serve(0, -1, 0, 2, 50, n);
        check_all_zero("abort");
        reset = 1'b0;
        #1;
        check("abort_release_cmd_ready", 64'(cmd_ready), 1);
        @(posedge sys_clk); #1;
        check("abort_idle_busy", 64'(busy), 0);
        check("abort_err_pulses", 64'(err_cnt - err0), 0);
        check("abort_rd_valid_pulses", 64'(rdv_cnt - rdv0), 2);
        beat_q.delete();
        rd_q.delete();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 Parameter dw, default 32: Wishbone data width in bits; wb_sel_o width is dw/8.
REQ-002 Parameter APP_AW, default 26: Wishbone byte-address width.
REQ-003 Parameter TMO_W, default 10: width of the ack-timeout counter; timeout limit is 2**TMO_W-1 cycles.
REQ-004 sys_clk  in  1  sole clock; all logic on its rising edge; reset is synchronous and active-high.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-007 cmd_addr  in  APP_AW  start byte address; cmd_we  in  1  1 = write burst; cmd_len  in  8  beat count, 0 treated as 1.
REQ-008 wr_valid / wr_ready  in / out  1 / 1  write-data handshake; wr_data  in  dw; wr_sel  in  dw/8.
REQ-009 rd_valid  out  1  read beat strobe, no backpressure; rd_data  out  dw; rd_last  out  1  final beat of burst.
REQ-010 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each; wb_addr_o  out  APP_AW; wb_dat_o  out  dw; wb_sel_o  out  dw/8; wb_cti_o  out  3.
REQ-011 wb_ack_i  in  1; wb_dat_i  in  dw  Wishbone slave response (SDRAM controller Wishbone port).
REQ-012 busy  out  1  burst in progress; err  out  1  one-cycle pulse on timeout abort.

Function
REQ-013 FSM states: IDLE, XFER, WSTALL, DONE.
REQ-014 IDLE: cmd_ready=1; on cmd_valid latch addr/we/len (0 -> 1), clear beat and timeout counters, go to XFER next cycle.
REQ-015 XFER: wb_cyc_o=1, wb_stb_o=1, wb_we_o=latched we, wb_addr_o=current address.
REQ-016 wb_cti_o=3'b010 on every beat except the last, which is 3'b111; a single-beat command uses 3'b111.
REQ-017 A beat completes on the edge where wb_stb_o and wb_ack_i are both 1: beat count +1, address += dw/8 (wraps modulo 2**APP_AW), timeout counter cleared.
REQ-018 Write beat: wb_dat_o/wb_sel_o are taken from wr_data/wr_sel; wr_ready = wb_stb_o & wb_ack_i & wb_we_o (pop on ack).
REQ-019 Write stall: in XFER with we=1 and wr_valid=0, go to WSTALL; WSTALL holds wb_cyc_o=1 and wb_stb_o=0 and returns to XFER the cycle after wr_valid=1.
REQ-020 Read beat: rd_valid=1 and rd_data=wb_dat_i in the same cycle as the ack (combinational pass-through); rd_last=1 on the final beat.
REQ-021 After the final ack, go to DONE; wb_cyc_o and wb_stb_o drop in that cycle; DONE lasts one cycle and then returns to IDLE.
REQ-022 Timeout: the counter increments in XFER while wb_ack_i=0; on reaching its limit, go to DONE, pulse err, and issue no further beats; rd_last is not asserted.
REQ-023 The timeout counter holds (no increment) in WSTALL.
REQ-024 wb_ack_i outside XFER is ignored.
REQ-025 cmd_ready=0 in every state except IDLE; busy=1 in XFER and WSTALL.

Reset
REQ-026 While reset=1: state=IDLE, and wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_addr_o, wb_sel_o, wb_dat_o, rd_valid, rd_last, busy, err are all 0; cmd_ready=0 during reset, 1 from the first cycle after.
REQ-027 Reset mid-burst drops wb_cyc_o on the next edge, discards the remaining beats, and does not pulse err.

Structure
REQ-028 Shared package wb_master_pkg holds the FSM state enum, CTI constants (CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111), and the beat-count width (8).
REQ-029 One sub-module, wb_ack_timer: timeout counter with clear/enable inputs and an expired output, parameterised by TMO_W.

Verification
REQ-030 Write burst: addr 0x100, len 4, wr_valid held high, slave acks every cycle -> addresses 0x100/0x104/0x108/0x10C, cti 010,010,010,111, four wr_ready pulses, wb_cyc_o low the cycle after the 4th ack.
REQ-031 Read burst: addr 0x2000, len 8, ack with 2-cycle gaps -> exactly 8 rd_valid pulses carrying wb_dat_i, rd_last only on the 8th.
REQ-032 Write stall: len 3, wr_valid low for 5 cycles before beat 2 -> wb_stb_o low for those cycles, wb_cyc_o stays high, no err.
REQ-033 Timeout: TMO_W=4, read len 2, slave never acks -> err pulses after 15 cycles in XFER, wb_cyc_o drops, FSM reaches IDLE.
REQ-034 Edge cases: cmd_len=0 -> one beat with cti 111; addr 0x3FFFFFC with len 2 -> second address 0x0000000.
REQ-035 Reset asserted during beat 3 of an 8-beat read -> all outputs 0 on the next edge, no err, cmd_ready=1 after reset releases.
